// File: rtl/wave_pkg.sv
// Shared types and default constants for the wave_meter measurement block.
package wave_pkg;

    // Crossing-detector state: SYNC waits for the first low level after reset/clear.
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } wm_state_t;

    localparam int WAVE_W    = 8;
    localparam int WAVE_MID  = 127;
    localparam int WAVE_HYST = 4;

endpackage : wave_pkg

// File: rtl/crossing_detector.sv
// Hysteresis comparator plus SYNC/LOW/HIGH FSM; emits a one-cycle rise pulse
// in the same cycle as the accepted sample that crosses the upper threshold.
import wave_pkg::*;

module crossing_detector #(
    parameter int WIDTH = WAVE_W,
    parameter int MID   = WAVE_MID,
    parameter int HYST  = WAVE_HYST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] wave,
    output logic             rise
);

    localparam logic [WIDTH-1:0] RISE_LVL = WIDTH'(MID + HYST);
    localparam logic [WIDTH-1:0] FALL_LVL = WIDTH'(MID - HYST);

    wm_state_t state_q;
    wm_state_t state_d;

    logic above;
    logic below;

    assign above = (wave >= RISE_LVL);
    assign below = (wave <= FALL_LVL);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and rise pulse; clear beats any crossing in the same cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        rise    = 1'b0;
        if (clr) begin
            state_d = SYNC;
        end else if (sample_en) begin
            case (state_q)
                SYNC: if (below) state_d = LOW;
                LOW: begin
                    if (above) begin
                        state_d = HIGH;
                        rise    = 1'b1;
                    end
                end
                HIGH: if (below) state_d = LOW;
                default: state_d = SYNC;
            endcase
        end
    end

endmodule : crossing_detector

// File: rtl/wave_meter.sv
// Period / peak / amplitude meter for an 8-bit sample stream. Measures between
// consecutive rising crossings and publishes each result with a one-cycle strobe.
import wave_pkg::*;

module wave_meter #(
    parameter int WIDTH = WAVE_W,
    parameter int MID   = WAVE_MID,
    parameter int HYST  = WAVE_HYST,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] wave,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [WIDTH-1:0] peak_max,
    output logic [WIDTH-1:0] peak_min,
    output logic [WIDTH-1:0] amplitude,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             rise;
    logic             accept;
    logic             armed;
    logic             ovf_r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] rmax;
    logic [WIDTH-1:0] rmin;
    logic [WIDTH-1:0] next_max;
    logic [WIDTH-1:0] next_min;

    crossing_detector #(
        .WIDTH (WIDTH),
        .MID   (MID),
        .HYST  (HYST)
    ) u_det (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .sample_en (sample_en),
        .wave      (wave),
        .rise      (rise)
    );

    assign accept = sample_en & ~clr;

    // Saturating count; doubles as the reported period (cnt+1) on a crossing.
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    // Running extremes including the current sample.
    assign next_max = (wave > rmax) ? wave : rmax;
    assign next_min = (wave < rmin) ? wave : rmin;

    // Running counter, extremes, sticky overflow and armed flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            rmax  <= '0;
            rmin  <= '0;
            ovf_r <= 1'b0;
            armed <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            rmax  <= '0;
            rmin  <= '0;
            ovf_r <= 1'b0;
            armed <= 1'b0;
        end else if (accept) begin
            if (rise) begin
                cnt   <= '0;
                rmax  <= wave;
                rmin  <= wave;
                ovf_r <= 1'b0;
                armed <= 1'b1;
            end else begin
                cnt   <= cnt_inc;
                // Reaching all-ones means the true period no longer fits the report.
                ovf_r <= ovf_r | (cnt_inc == CNT_MAX);
                rmax  <= next_max;
                rmin  <= next_min;
            end
        end
    end

    // Result registers: latched on an armed rising crossing, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meas_valid <= 1'b0;
            period     <= '0;
            peak_max   <= '0;
            peak_min   <= '0;
            amplitude  <= '0;
            overflow   <= 1'b0;
        end else if (clr) begin
            meas_valid <= 1'b0;
            period     <= '0;
            peak_max   <= '0;
            peak_min   <= '0;
            amplitude  <= '0;
            overflow   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (rise && armed) begin
                meas_valid <= 1'b1;
                period     <= cnt_inc;
                peak_max   <= next_max;
                peak_min   <= next_min;
                // next_max >= next_min always, so this never wraps.
                amplitude  <= next_max - next_min;
                overflow   <= ovf_r;
            end
        end
    end

endmodule : wave_meter

// File: tb/tb_wave_meter.sv
// Directed bench for wave_meter: a table of hand-computed vectors followed by
// multi-cycle sequences (square, hysteresis, gated enable, overflow, triangle, reset).
module tb_wave_meter;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        sample_en;
    logic [7:0]  wave;

    logic        meas_valid;
    logic [15:0] period;
    logic [7:0]  peak_max;
    logic [7:0]  peak_min;
    logic [7:0]  amplitude;
    logic        overflow;

    logic        meas_valid4;
    logic [3:0]  period4;
    logic [7:0]  peak_max4;
    logic [7:0]  peak_min4;
    logic [7:0]  amplitude4;
    logic        overflow4;

    int n_vec  = 0;
    int n_fail = 0;

    wave_meter #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .sample_en  (sample_en),
        .wave       (wave),
        .meas_valid (meas_valid),
        .period     (period),
        .peak_max   (peak_max),
        .peak_min   (peak_min),
        .amplitude  (amplitude),
        .overflow   (overflow)
    );

    wave_meter #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .sample_en  (sample_en),
        .wave       (wave),
        .meas_valid (meas_valid4),
        .period     (period4),
        .peak_max   (peak_max4),
        .peak_min   (peak_min4),
        .amplitude  (amplitude4),
        .overflow   (overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  wave;
        logic        en;
        logic        clr;
        logic        v;
        logic [15:0] per;
        logic [7:0]  mx;
        logic [7:0]  mn;
        logic [7:0]  amp;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [15:0] per,
                             input logic [7:0] mx, input logic [7:0] mn,
                             input logic [7:0] amp, input logic ovf);
        check({tag, ".valid"},  32'(meas_valid), 32'(v));
        check({tag, ".period"}, 32'(period),     32'(per));
        check({tag, ".max"},    32'(peak_max),   32'(mx));
        check({tag, ".min"},    32'(peak_min),   32'(mn));
        check({tag, ".amp"},    32'(amplitude),  32'(amp));
        check({tag, ".ovf"},    32'(overflow),   32'(ovf));
    endtask

    // Apply one set of inputs, let one rising edge act on it, sample 1 ns later.
    task automatic step(input logic [7:0] w, input logic en, input logic c);
        wave      = w;
        sample_en = en;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sq(input int i);
        return ((i % 10) < 5) ? 8'd0 : 8'd255;
    endfunction

    function automatic logic [7:0] tri_wave(input int i);
        int p;
        p = i % 254;
        return (p <= 127) ? 8'(2 * p) : 8'(2 * (254 - p));
    endfunction

    function automatic vec_t mk(input logic [7:0] w, input logic en, input logic c,
                                input logic v, input logic [15:0] per, input logic [7:0] mx,
                                input logic [7:0] mn, input logic [7:0] amp, input logic ovf);
        vec_t r;
        r.wave = w; r.en = en; r.clr = c; r.v = v; r.per = per;
        r.mx = mx; r.mn = mn; r.amp = amp; r.ovf = ovf;
        return r;
    endfunction

    vec_t vecs[18];

    initial begin
        logic exp_v;

        // wave, en, clr -> valid, period, max, min, amp, ovf (after the edge)
        vecs[0]  = mk(8'd200, 1, 0, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0); // SYNC ignores high
        vecs[1]  = mk(8'd100, 1, 0, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0); // -> LOW
        vecs[2]  = mk(8'd140, 0, 0, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0); // not enabled
        vecs[3]  = mk(8'd140, 1, 0, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0); // first rise: arm only
        vecs[4]  = mk(8'd180, 1, 0, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0);
        vecs[5]  = mk(8'd125, 1, 0, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0); // in band
        vecs[6]  = mk(8'd60,  1, 0, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0); // -> LOW
        vecs[7]  = mk(8'd130, 1, 0, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0); // just below rise level
        vecs[8]  = mk(8'd131, 1, 0, 1, 16'd5, 8'd180, 8'd60,  8'd120, 0); // exact rise level
        vecs[9]  = mk(8'd131, 1, 0, 0, 16'd5, 8'd180, 8'd60,  8'd120, 0); // hold
        vecs[10] = mk(8'd123, 1, 0, 0, 16'd5, 8'd180, 8'd60,  8'd120, 0); // exact fall level
        vecs[11] = mk(8'd255, 1, 0, 1, 16'd3, 8'd255, 8'd123, 8'd132, 0);
        vecs[12] = mk(8'd0,   1, 0, 0, 16'd3, 8'd255, 8'd123, 8'd132, 0); // -> LOW
        vecs[13] = mk(8'd200, 1, 1, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0); // clr beats crossing
        vecs[14] = mk(8'd0,   1, 0, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0);
        vecs[15] = mk(8'd200, 1, 0, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0); // re-arm
        vecs[16] = mk(8'd0,   1, 0, 0, 16'd0, 8'd0,   8'd0,   8'd0,   0);
        vecs[17] = mk(8'd200, 1, 0, 1, 16'd2, 8'd200, 8'd0,   8'd200, 0); // minimum period

        rst = 1'b0; clr = 1'b0; sample_en = 1'b0; wave = 8'd0;
        #12;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset", 0, 16'd0, 8'd0, 8'd0, 8'd0, 0);

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].wave, vecs[i].en, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].per,
                      vecs[i].mx, vecs[i].mn, vecs[i].amp, vecs[i].ovf);
        end

        // Square wave, every sample enabled.
        step(8'd0, 0, 1);
        for (int i = 0; i < 60; i++) begin
            step(sq(i), 1, 0);
            exp_v = (i >= 15) && (i % 10 == 5);
            check($sformatf("sq.valid[%0d]", i), 32'(meas_valid), 32'(exp_v));
            if (exp_v) check_all("sq", 1, 16'd10, 8'd255, 8'd0, 8'd255, 0);
        end

        // Hysteresis: in-band chatter must never cross.
        step(8'd0, 0, 1);
        step(8'd0, 1, 0);
        for (int i = 0; i < 100; i++) begin
            step((i % 2 == 0) ? 8'd125 : 8'd129, 1, 0);
            check($sformatf("hyst.valid[%0d]", i), 32'(meas_valid), 32'd0);
        end
        step(8'd255, 1, 0);
        check("hyst.first_rise", 32'(meas_valid), 32'd0);

        // Enable on alternate clocks; disabled clocks carry the opposite level.
        step(8'd0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            step(sq(i), 1, 0);
            exp_v = (i >= 15) && (i % 10 == 5);
            check($sformatf("gate.valid[%0d]", i), 32'(meas_valid), 32'(exp_v));
            if (exp_v) check("gate.period", 32'(period), 32'd10);
            step(8'd255 - sq(i), 0, 0);
            check($sformatf("gate.idle[%0d]", i), 32'(meas_valid), 32'd0);
        end

        // Overflow on the 4-bit counter instance; 16-bit instance measures exactly.
        step(8'd0, 0, 1);
        step(8'd0, 1, 0);
        step(8'd255, 1, 0);
        for (int i = 0; i < 30; i++) step(8'd0, 1, 0);
        step(8'd255, 1, 0);
        check("ovf4.valid",  32'(meas_valid4), 32'd1);
        check("ovf4.period", 32'(period4),     32'd15);
        check("ovf4.ovf",    32'(overflow4),   32'd1);
        check("ovf4.amp",    32'(amplitude4),  32'd255);
        check("ovf16.period", 32'(period),     32'd31);
        check("ovf16.ovf",    32'(overflow),   32'd0);
        for (int i = 0; i < 4; i++) step(8'd255, 1, 0);
        for (int i = 0; i < 5; i++) step(8'd0, 1, 0);
        step(8'd255, 1, 0);
        check("ovf4.next_valid",  32'(meas_valid4), 32'd1);
        check("ovf4.next_period", 32'(period4),     32'd10);
        check("ovf4.next_ovf",    32'(overflow4),   32'd0);

        // Triangle 0..254..2 with step 2.
        step(8'd0, 0, 1);
        for (int i = 0; i <= 66 + 2 * 254; i++) begin
            step(tri_wave(i), 1, 0);
            exp_v = (i > 66) && ((i - 66) % 254 == 0);
            check($sformatf("tri.valid[%0d]", i), 32'(meas_valid), 32'(exp_v));
            if (exp_v) check_all("tri", 1, 16'd254, 8'd254, 8'd0, 8'd254, 0);
        end

        // Asynchronous reset mid-cycle, then two crossings needed for a report.
        step(8'd0, 0, 1);
        for (int i = 0; i < 18; i++) step(sq(i), 1, 0);
        check("pre_rst.period", 32'(period), 32'd10);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 0, 16'd0, 8'd0, 8'd0, 8'd0, 0);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(sq(i), 1, 0);
            exp_v = (i >= 15) && (i % 10 == 5);
            check($sformatf("post_rst.valid[%0d]", i), 32'(meas_valid), 32'(exp_v));
            if (exp_v) check("post_rst.period", 32'(period), 32'd10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_wave_meter
